wb_tile_sched: RTL and testbench

Sequencer for the write-back stage. Takes one layer-level output command, splits the output feature-map width into column tiles that fit the psum buffer, and issues one write-back configuration per tile over the write-back ctrl handshake. Waits for each tile's completion and releases the psum buffer slot. Tracks the compressed feature-map and guard write pointers across the layer. Sits between the layer controller and the write-back unit.

---
 rtl/wb_tile_sched_pkg.sv | 17 +
 rtl/wb_tile_sched_wr_ptr.sv | 20 ++
 rtl/wb_tile_sched.sv | 140 ++++++++++++++
 tb/tb_wb_tile_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_tile_sched_pkg.sv
// Shared types and constants for the write-back tile scheduler.
package wb_tile_sched_pkg;

  localparam int PSUM_BUF_DEPTH = 32;
  localparam int MAX_TILE_W_DEF = PSUM_BUF_DEPTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT    = 3'd2,
    S_ISSUE   = 3'd3,
    S_RUN     = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6
  } wb_sched_state_t;

endpackage

// File: rtl/wb_tile_sched_wr_ptr.sv
// Write pointer with synchronous clear and a single-step increment; wraps silently.
module wr_ptr_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wb_tile_sched.sv
// Splits one layer output command into psum-buffer-sized column tiles and
// drives the write-back unit one tile at a time, tracking fm/guard pointers.
module wb_tile_sched
  import wb_tile_sched_pkg::*;
#(
  parameter int MAX_TILE_W = MAX_TILE_W_DEF,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [3:0]        cmd_shift,
  input  logic              cmd_is_diff,
  input  logic              cmd_is_last,
  input  logic              psum_tile_valid,
  output logic              psum_tile_ack,
  output logic              wb_ctrl_valid,
  input  logic              wb_ctrl_ready,
  input  logic              wb_ctrl_finish,
  output logic [7:0]        wb_w_num,
  output logic [7:0]        wb_h_num,
  output logic [7:0]        wb_w_cut,
  output logic [3:0]        wb_shift,
  output logic              wb_is_diff,
  output logic              wb_is_last,
  input  logic              wb_data_valid,
  input  logic              wb_guard_valid,
  output logic [ADDR_W-1:0] fm_wr_addr,
  output logic [ADDR_W-1:0] guard_wr_addr,
  output logic              busy,
  output logic              layer_done
);

  localparam logic [7:0] TILE_W = 8'(MAX_TILE_W);

  wb_sched_state_t state, state_nxt;
  logic [7:0]      rem_w;
  logic            last_tile;
  logic            accept;
  logic            zero_cmd;

  function automatic logic [7:0] clip_tile_w(input logic [7:0] rem);
    return (rem > TILE_W) ? TILE_W : rem;
  endfunction

  assign accept   = (state == S_IDLE) && cmd_valid;
  assign zero_cmd = (cmd_w == 8'd0) || (cmd_h == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_valid) state_nxt = zero_cmd ? S_DONE : S_LOAD;
      S_LOAD:    state_nxt = S_WAIT;
      S_WAIT:    if (psum_tile_valid) state_nxt = S_ISSUE;
      S_ISSUE:   if (wb_ctrl_ready) state_nxt = S_RUN;
      S_RUN:     if (wb_ctrl_finish) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = last_tile ? S_DONE : S_LOAD;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = 1'b0;
    wb_ctrl_valid = 1'b0;
    psum_tile_ack = 1'b0;
    layer_done    = 1'b0;
    busy          = 1'b1;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_ISSUE:   wb_ctrl_valid = 1'b1;
      S_RELEASE: psum_tile_ack = 1'b1;
      S_DONE:    layer_done    = 1'b1;
      default:   ;
    endcase
  end

  // Tile config is held from LOAD until the next LOAD so the write-back unit
  // sees a stable word for the whole tile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_w      <= '0;
      last_tile  <= 1'b0;
      wb_w_num   <= '0;
      wb_w_cut   <= '0;
      wb_h_num   <= '0;
      wb_shift   <= '0;
      wb_is_diff <= 1'b0;
      wb_is_last <= 1'b0;
    end else begin
      if (accept) begin
        rem_w      <= cmd_w;
        last_tile  <= 1'b0;
        wb_h_num   <= cmd_h;
        wb_shift   <= cmd_shift;
        wb_is_diff <= cmd_is_diff;
        wb_is_last <= cmd_is_last;
      end
      if (state == S_LOAD) begin
        wb_w_num  <= clip_tile_w(rem_w);
        wb_w_cut  <= TILE_W - clip_tile_w(rem_w);
        last_tile <= (rem_w <= TILE_W);
      end
      if (state == S_RELEASE) begin
        rem_w <= rem_w - wb_w_num;
      end
    end
  end

  wr_ptr_cnt #(.W(ADDR_W)) u_fm_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (busy && wb_data_valid),
    .cnt   (fm_wr_addr)
  );

  wr_ptr_cnt #(.W(ADDR_W)) u_guard_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (busy && wb_guard_valid),
    .cnt   (guard_wr_addr)
  );

endmodule

// File: tb/tb_wb_tile_sched.sv
// Directed bench for wb_tile_sched: tiling, handshakes, pointers, reset.
module tb_wb_tile_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_w, cmd_h;
  logic [3:0]  cmd_shift;
  logic        cmd_is_diff, cmd_is_last;
  logic        psum_tile_valid, psum_tile_ack;
  logic        wb_ctrl_valid, wb_ctrl_ready, wb_ctrl_finish;
  logic [7:0]  wb_w_num, wb_h_num, wb_w_cut;
  logic [3:0]  wb_shift;
  logic        wb_is_diff, wb_is_last;
  logic        wb_data_valid, wb_guard_valid;
  logic [15:0] fm_wr_addr, guard_wr_addr;
  logic        busy, layer_done;

  logic        d4_cmd_ready, d4_ack, d4_vld, d4_busy, d4_done;
  logic [7:0]  d4_w_num, d4_h_num, d4_w_cut;
  logic [3:0]  d4_shift;
  logic        d4_diff, d4_last;
  logic [3:0]  d4_fm, d4_guard;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0, ack_cnt = 0, done_cnt = 0, vld_cnt = 0;

  always #5 clk = ~clk;

  wb_tile_sched #(.MAX_TILE_W(32), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_shift(cmd_shift), .cmd_is_diff(cmd_is_diff),
    .cmd_is_last(cmd_is_last), .psum_tile_valid(psum_tile_valid), .psum_tile_ack(psum_tile_ack),
    .wb_ctrl_valid(wb_ctrl_valid), .wb_ctrl_ready(wb_ctrl_ready), .wb_ctrl_finish(wb_ctrl_finish),
    .wb_w_num(wb_w_num), .wb_h_num(wb_h_num), .wb_w_cut(wb_w_cut), .wb_shift(wb_shift),
    .wb_is_diff(wb_is_diff), .wb_is_last(wb_is_last), .wb_data_valid(wb_data_valid),
    .wb_guard_valid(wb_guard_valid), .fm_wr_addr(fm_wr_addr), .guard_wr_addr(guard_wr_addr),
    .busy(busy), .layer_done(layer_done)
  );

  wb_tile_sched #(.MAX_TILE_W(32), .ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(d4_cmd_ready),
    .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_shift(cmd_shift), .cmd_is_diff(cmd_is_diff),
    .cmd_is_last(cmd_is_last), .psum_tile_valid(psum_tile_valid), .psum_tile_ack(d4_ack),
    .wb_ctrl_valid(d4_vld), .wb_ctrl_ready(wb_ctrl_ready), .wb_ctrl_finish(wb_ctrl_finish),
    .wb_w_num(d4_w_num), .wb_h_num(d4_h_num), .wb_w_cut(d4_w_cut), .wb_shift(d4_shift),
    .wb_is_diff(d4_diff), .wb_is_last(d4_last), .wb_data_valid(wb_data_valid),
    .wb_guard_valid(wb_guard_valid), .fm_wr_addr(d4_fm), .guard_wr_addr(d4_guard),
    .busy(d4_busy), .layer_done(d4_done)
  );

  // Event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wb_ctrl_valid && wb_ctrl_ready) hs_cnt++;
    if (wb_ctrl_valid) vld_cnt++;
    if (psum_tile_ack) ack_cnt++;
    if (layer_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int w, input int h, input int sh, input bit diff, input bit last);
    cmd_w = 8'(w); cmd_h = 8'(h); cmd_shift = 4'(sh);
    cmd_is_diff = diff; cmd_is_last = last;
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL send_cmd ready: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Drives one tile from LOAD/WAIT through RELEASE; returns in the cycle after the ack.
  task automatic do_tile(input int exp_w, input int exp_cut, input int psum_wait,
                         input int ready_wait, input string nm, output int lat);
    bit early, stable;
    int n;
    psum_tile_valid = 1'b0;
    wb_ctrl_ready   = (ready_wait == 0);
    early = 1'b0;
    for (int i = 0; i < psum_wait; i++) begin
      tick();
      if (wb_ctrl_valid) early = 1'b1;
    end
    if (psum_wait > 0) begin
      total++;
      if (early !== 1'b0) begin
        bad++; $display("FAIL %s early_valid: got %b want 0", nm, early);
      end
    end
    psum_tile_valid = 1'b1;
    n = 0;
    while (wb_ctrl_valid !== 1'b1 && n < 60) begin
      tick(); n++;
    end
    lat = n;
    total++;
    if (wb_ctrl_valid !== 1'b1) begin
      bad++; $display("FAIL %s valid_timeout: got %b want 1", nm, wb_ctrl_valid);
    end
    total++;
    if (wb_w_num !== 8'(exp_w)) begin
      bad++; $display("FAIL %s w_num: got %0d want %0d", nm, wb_w_num, exp_w);
    end
    total++;
    if (wb_w_cut !== 8'(exp_cut)) begin
      bad++; $display("FAIL %s w_cut: got %0d want %0d", nm, wb_w_cut, exp_cut);
    end
    if (ready_wait > 0) begin
      stable = 1'b1;
      for (int i = 0; i < ready_wait; i++) begin
        wb_ctrl_finish = (i == 0);
        tick();
        wb_ctrl_finish = 1'b0;
        if (wb_ctrl_valid !== 1'b1 || wb_w_num !== 8'(exp_w) || wb_w_cut !== 8'(exp_cut)) stable = 1'b0;
      end
      total++;
      if (stable !== 1'b1) begin
        bad++; $display("FAIL %s issue_stable: got %b want 1", nm, stable);
      end
      wb_ctrl_ready = 1'b1;
    end
    tick();
    wb_ctrl_ready   = 1'b0;
    psum_tile_valid = 1'b0;
    total++;
    if (wb_ctrl_valid !== 1'b0) begin
      bad++; $display("FAIL %s valid_after_hs: got %b want 0", nm, wb_ctrl_valid);
    end
    repeat (3) tick();
    total++;
    if (wb_w_num !== 8'(exp_w)) begin
      bad++; $display("FAIL %s w_num_run: got %0d want %0d", nm, wb_w_num, exp_w);
    end
    wb_ctrl_finish = 1'b1;
    tick();
    wb_ctrl_finish = 1'b0;
    total++;
    if (psum_tile_ack !== 1'b1) begin
      bad++; $display("FAIL %s ack: got %b want 1", nm, psum_tile_ack);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_w = '0; cmd_h = '0; cmd_shift = '0;
    cmd_is_diff = 1'b0; cmd_is_last = 1'b0;
    psum_tile_valid = 1'b0; wb_ctrl_ready = 1'b0; wb_ctrl_finish = 1'b0;
    wb_data_valid = 1'b1; wb_guard_valid = 1'b1;
    repeat (3) tick();
    wb_data_valid = 1'b0; wb_guard_valid = 1'b0;
    total++;
    if ({cmd_ready, busy, wb_ctrl_valid, psum_tile_ack, layer_done} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 10000",
                      {cmd_ready, busy, wb_ctrl_valid, psum_tile_ack, layer_done});
    end
    total++;
    if ({wb_w_num, wb_h_num, wb_w_cut, wb_shift, wb_is_diff, wb_is_last} !== 30'd0) begin
      bad++; $display("FAIL reset_cfg: got w=%0d h=%0d cut=%0d sh=%0d", wb_w_num, wb_h_num, wb_w_cut, wb_shift);
    end
    total++;
    if (fm_wr_addr !== 16'd0 || guard_wr_addr !== 16'd0) begin
      bad++; $display("FAIL reset_ptr: got fm=%0d guard=%0d want 0/0", fm_wr_addr, guard_wr_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lat, a0, h0, d0;
    a0 = ack_cnt; h0 = hs_cnt; d0 = done_cnt;
    send_cmd(10, 3, 5, 1'b1, 1'b0);
    total++;
    if (busy !== 1'b1 || wb_h_num !== 8'd3 || wb_shift !== 4'd5 || wb_is_diff !== 1'b1 || wb_is_last !== 1'b0) begin
      bad++; $display("FAIL single_latch: got busy=%b h=%0d sh=%0d diff=%b last=%b want 1/3/5/1/0",
                      busy, wb_h_num, wb_shift, wb_is_diff, wb_is_last);
    end
    do_tile(10, 22, 0, 0, "single", lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL single_issue_latency: got %0d want 2", lat);
    end
    total++;
    if (layer_done !== 1'b1 || psum_tile_ack !== 1'b0) begin
      bad++; $display("FAIL single_done: got done=%b ack=%b want 1/0", layer_done, psum_tile_ack);
    end
    tick();
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || layer_done !== 1'b0) begin
      bad++; $display("FAIL single_idle: got ready=%b busy=%b done=%b want 1/0/0", cmd_ready, busy, layer_done);
    end
    total++;
    if (ack_cnt - a0 !== 1 || hs_cnt - h0 !== 1 || done_cnt - d0 !== 1) begin
      bad++; $display("FAIL single_counts: got ack=%0d hs=%0d done=%0d want 1/1/1",
                      ack_cnt - a0, hs_cnt - h0, done_cnt - d0);
    end
  endtask

  task automatic test_multi();
    int lat, a0, h0, d0;
    int exp_w[3]   = '{32, 32, 6};
    int exp_cut[3] = '{0, 0, 26};
    a0 = ack_cnt; h0 = hs_cnt; d0 = done_cnt;
    send_cmd(70, 4, 2, 1'b0, 1'b1);
    for (int t = 0; t < 3; t++) begin
      if (t == 1) begin
        cmd_w = 8'd5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
      end
      do_tile(exp_w[t], exp_cut[t], 0, 0, "multi", lat);
      total++;
      if (layer_done !== (t == 2)) begin
        bad++; $display("FAIL multi_done_tile%0d: got %b want %b", t, layer_done, (t == 2));
      end
    end
    tick();
    total++;
    if (ack_cnt - a0 !== 3 || hs_cnt - h0 !== 3 || done_cnt - d0 !== 1) begin
      bad++; $display("FAIL multi_counts: got ack=%0d hs=%0d done=%0d want 3/3/1",
                      ack_cnt - a0, hs_cnt - h0, done_cnt - d0);
    end
    total++;
    if (wb_is_last !== 1'b1 || wb_h_num !== 8'd4) begin
      bad++; $display("FAIL multi_cfg: got last=%b h=%0d want 1/4", wb_is_last, wb_h_num);
    end
  endtask

  task automatic test_stall();
    int lat, h0;
    h0 = hs_cnt;
    send_cmd(40, 2, 0, 1'b0, 1'b0);
    do_tile(32, 0, 20, 5, "stall0", lat);
    do_tile(8, 24, 20, 5, "stall1", lat);
    total++;
    if (layer_done !== 1'b1) begin
      bad++; $display("FAIL stall_done: got %b want 1", layer_done);
    end
    tick();
    total++;
    if (hs_cnt - h0 !== 2) begin
      bad++; $display("FAIL stall_handshakes: got %0d want 2", hs_cnt - h0);
    end
  endtask

  task automatic test_zero();
    int seen, v0, a0;
    v0 = vld_cnt; a0 = ack_cnt;
    send_cmd(0, 5, 0, 1'b0, 1'b0);
    seen = 0;
    if (layer_done === 1'b1) seen++;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL zero_busy_ready: got %b want 0", cmd_ready);
    end
    cmd_w = 8'd10; cmd_h = 8'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    if (layer_done === 1'b1) seen++;
    total++;
    if (seen !== 1) begin
      bad++; $display("FAIL zero_done: got %0d pulses want 1", seen);
    end
    repeat (5) tick();
    total++;
    if (busy !== 1'b0 || vld_cnt - v0 !== 0 || ack_cnt - a0 !== 0) begin
      bad++; $display("FAIL zero_quiet: got busy=%b valid_cycles=%0d acks=%0d want 0/0/0",
                      busy, vld_cnt - v0, ack_cnt - a0);
    end
  endtask

  task automatic test_ptr();
    int lat;
    send_cmd(40, 2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 37; i++) begin
      wb_data_valid = 1'b1; wb_guard_valid = (i < 5);
      tick();
    end
    wb_data_valid = 1'b0; wb_guard_valid = 1'b0;
    total++;
    if (fm_wr_addr !== 16'd37 || guard_wr_addr !== 16'd5) begin
      bad++; $display("FAIL ptr_count: got fm=%0d guard=%0d want 37/5", fm_wr_addr, guard_wr_addr);
    end
    do_tile(32, 0, 0, 0, "ptr0", lat);
    do_tile(8, 24, 0, 0, "ptr1", lat);
    tick();
    wb_data_valid = 1'b1; wb_guard_valid = 1'b1;
    repeat (3) tick();
    wb_data_valid = 1'b0; wb_guard_valid = 1'b0;
    total++;
    if (fm_wr_addr !== 16'd37 || guard_wr_addr !== 16'd5 || busy !== 1'b0) begin
      bad++; $display("FAIL ptr_hold: got fm=%0d guard=%0d busy=%b want 37/5/0", fm_wr_addr, guard_wr_addr, busy);
    end
  endtask

  task automatic test_wrap();
    int lat;
    send_cmd(10, 1, 0, 1'b0, 1'b0);
    total++;
    if (fm_wr_addr !== 16'd0 || guard_wr_addr !== 16'd0) begin
      bad++; $display("FAIL wrap_clear: got fm=%0d guard=%0d want 0/0", fm_wr_addr, guard_wr_addr);
    end
    for (int i = 0; i < 18; i++) begin
      wb_data_valid = 1'b1;
      tick();
    end
    wb_data_valid = 1'b0;
    total++;
    if (d4_fm !== 4'd2 || fm_wr_addr !== 16'd18) begin
      bad++; $display("FAIL wrap_fm: got narrow=%0d wide=%0d want 2/18", d4_fm, fm_wr_addr);
    end
    do_tile(10, 22, 0, 0, "wrap", lat);
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, a0, d0, n;
    send_cmd(40, 2, 3, 1'b1, 1'b0);
    psum_tile_valid = 1'b1; wb_ctrl_ready = 1'b1;
    n = 0;
    while (wb_ctrl_valid !== 1'b1 && n < 20) begin
      tick(); n++;
    end
    tick();
    wb_ctrl_ready = 1'b0; psum_tile_valid = 1'b0;
    wb_data_valid = 1'b1;
    repeat (3) tick();
    total++;
    if (fm_wr_addr !== 16'd3 || wb_ctrl_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_run: got fm=%0d valid=%b want 3/0", fm_wr_addr, wb_ctrl_valid);
    end
    a0 = ack_cnt; d0 = done_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wb_data_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || fm_wr_addr !== 16'd0 || wb_w_num !== 8'd0) begin
      bad++; $display("FAIL midrst_state: got ready=%b busy=%b fm=%0d w=%0d want 1/0/0/0",
                      cmd_ready, busy, fm_wr_addr, wb_w_num);
    end
    wb_ctrl_finish = 1'b1;
    tick();
    wb_ctrl_finish = 1'b0;
    repeat (3) tick();
    total++;
    if (ack_cnt - a0 !== 0 || done_cnt - d0 !== 0) begin
      bad++; $display("FAIL midrst_quiet: got acks=%0d done=%0d want 0/0", ack_cnt - a0, done_cnt - d0);
    end
    send_cmd(10, 3, 0, 1'b0, 1'b0);
    do_tile(10, 22, 0, 0, "midrst_new", lat);
    total++;
    if (layer_done !== 1'b1) begin
      bad++; $display("FAIL midrst_new_done: got %b want 1", layer_done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_zero();
    test_ptr();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
